flash_loader: RTL and testbench
===============================

Name: flash_loader

Overview:
- Parametrised SPI-flash-to-cache bulk loader. Reads a programmable byte range from SPI NOR flash using command 0x03, mode 0.
- Packs bytes little-endian into 32-bit words and writes each word into the Cache through its address/data_in/write_enable/busy port.
- Replaces the fixed 64 KiB, address-0 boot-load sequence. Adds a start/busy/done handshake, runtime source/destination/length, and a configurable SPI clock rate.
- Sits between the flash pins and the Cache port. Same clock domain as the cache port.

Parameters:
- SPI_HALF_PERIOD, 1, sys_clk cycles per flash_clk half-period (>=1).
- STARTUP_WAIT, 10, sys_clk cycles after reset before the first start is accepted.
- ADDR_WIDTH, 32, cache address width.
- LEN_WIDTH, 24, byte_count width.
- READ_CMD, 8'h03, flash read opcode.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  level sampled in IDLE; launches a transfer.
- flash_src_addr  in  24  flash byte address, latched at start.
- cache_dst_addr  in  ADDR_WIDTH  first cache address, latched at start. Bits [1:0] forced to 0.
- byte_count  in  LEN_WIDTH  bytes to transfer, latched at start. Bits [1:0] ignored (whole words only).
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at transfer end.
- flash_clk  out  1  SPI clock, idle low.
- flash_mosi  out  1  SPI data out.
- flash_miso  in  1  SPI data in.
- flash_cs  out  1  chip select, active low.
- cache_address  out  ADDR_WIDTH  cache word address.
- cache_data_in  out  32  word to write.
- cache_write_enable  out  4  byte enables.
- cache_busy  in  1  cache busy.

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: flash_cs=1, flash_clk=0, flash_mosi=0, busy=0, done=0, cache_write_enable=0, cache_address=0, cache_data_in=0.
  - State=POWER_WAIT. An aborted transfer is not resumed.
- States:
  - POWER_WAIT: count STARTUP_WAIT cycles, then go to IDLE.
  - IDLE: on start=1, latch inputs and set busy=1.
    - Word count = byte_count>>2. If zero: pulse done next cycle, flash_cs stays high, return to IDLE.
    - Otherwise go to CMD.
  - CMD: flash_cs=0; shift READ_CMD MSB-first (8 bits). Then go to ADDR.
  - ADDR: shift flash_src_addr MSB-first (24 bits). Then go to READ.
  - READ: clock in 4 bytes, MSB-first within each byte. Then go to WR_START.
  - WR_START: drive cache_address, cache_data_in={b3,b2,b1,b0} (b0 = first byte received) and cache_write_enable=4'b1111 for one cycle. Then go to WR_WAIT.
  - WR_WAIT: hold address, data and enable. On the first cycle with cache_busy=0:
    - drop enable to 0;
    - increment cache_address by 4 (wraps modulo 2^ADDR_WIDTH);
    - decrement the word counter;
    - go to READ if words remain, else FINISH.
  - FINISH: flash_cs=1, busy=0, done=1 for one cycle, then IDLE.
- SPI timing (mode 0):
  - flash_mosi changes only while flash_clk is low; flash_miso is sampled on the sys_clk edge that raises flash_clk.
  - Each half-period lasts exactly SPI_HALF_PERIOD cycles.
  - One bit costs 2*SPI_HALF_PERIOD cycles.
  - flash_clk is held low in WR_START/WR_WAIT. flash_cs stays low across words, so the flash read is one continuous stream.
- Latency: minimum per word (cache_busy=0) = 64*SPI_HALF_PERIOD+2 cycles. Command+address overhead = 64*SPI_HALF_PERIOD cycles.
- Handshakes:
  - start while busy=1 is ignored.
  - start held high after done launches a new transfer from IDLE.
  - Input changes after the start cycle have no effect.
- Flash address wrap at 2^24 is the flash's own behaviour; the block does not track it.

Optional Feature:
- Macro: FLASH_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], the modulo-2^32 sum of all words written in the current transfer.
  - Cleared to 0 when start is accepted; updated at each WR_WAIT exit.
  - Valid and stable from done until the next accepted start. Reset value 0.
- Undefined: the port and adder do not exist; all other behaviour is identical.

Test Plan:
- Reset release, STARTUP_WAIT=10, start held high from cycle 0 -> start not accepted until POWER_WAIT ends; busy rises at cycle >=11; flash_cs falls one cycle later.
- Flash model returns bytes 0xCD,0xAB,0x34,0x12,0x78,0x56,0x34,0x12; src=0x000100, dst=0x40, count=8, SPI_HALF_PERIOD=1 -> MOSI stream 0x03,0x00,0x01,0x00; writes 0x1234ABCD@0x40 and 0x12345678@0x44 with enable 4'b1111; done pulses once; flash_cs high after done.
- cache_busy held high for 5 cycles after each WR_START -> enable/address/data stable throughout; flash_clk low throughout; next word bits resume only after busy falls.
- byte_count=3 -> done pulses the cycle after start accepted; flash_cs never falls; no cache write.
- sys_rst_n asserted mid-READ of word 2 -> same-cycle flash_cs=1, flash_clk=0, enable=0, busy=0; after release, a new start restarts from CMD.
- FLASH_LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 at done; then a second start with count=0 -> checksum=0.

Source files
------------

// File: rtl/flash_loader.sv
// SPI NOR (mode 0) to cache bulk loader: streams a flash byte range into 32-bit little-endian cache writes.
// Define FLASH_LOADER_CHECKSUM_EN to add a running sum of the words written in each transfer.
module flash_loader #(
  parameter int         SPI_HALF_PERIOD = 1,
  parameter int         STARTUP_WAIT    = 10,
  parameter int         ADDR_WIDTH      = 32,
  parameter int         LEN_WIDTH       = 24,
  parameter logic [7:0] READ_CMD        = 8'h03
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [23:0]           flash_src_addr,
  input  logic [ADDR_WIDTH-1:0] cache_dst_addr,
  input  logic [LEN_WIDTH-1:0]  byte_count,
  output logic                  busy,
  output logic                  done,
  output logic                  flash_clk,
  output logic                  flash_mosi,
  input  logic                  flash_miso,
  output logic                  flash_cs,
  output logic [ADDR_WIDTH-1:0] cache_address,
  output logic [31:0]           cache_data_in,
  output logic [3:0]            cache_write_enable,
`ifdef FLASH_LOADER_CHECKSUM_EN
  output logic [31:0]           checksum,
`endif
  input  logic                  cache_busy
);

  localparam int DIV_W = (SPI_HALF_PERIOD > 1) ? $clog2(SPI_HALF_PERIOD) : 1;
  localparam int WRD_W = LEN_WIDTH - 2;

  typedef enum logic [2:0] {
    S_POWER_WAIT, S_IDLE, S_CMD, S_ADDR, S_READ, S_WR_START, S_WR_WAIT, S_FINISH
  } state_t;

  state_t            r_state;
  logic [31:0]       r_wait;
  logic [DIV_W-1:0]  r_div;
  logic [4:0]        r_bits;
  logic [31:0]       r_sh;
  logic [31:0]       r_rx;
  logic [WRD_W-1:0]  r_words;

  logic w_half_done;
  logic w_unused;

  assign w_half_done = (r_div == DIV_W'(SPI_HALF_PERIOD - 1));
  assign w_unused    = &{1'b0, byte_count[1:0], cache_dst_addr[1:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state            <= S_POWER_WAIT;
      r_wait             <= '0;
      r_div              <= '0;
      r_bits             <= '0;
      r_sh               <= '0;
      r_rx               <= '0;
      r_words            <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      flash_clk          <= 1'b0;
      flash_mosi         <= 1'b0;
      flash_cs           <= 1'b1;
      cache_address      <= '0;
      cache_data_in      <= '0;
      cache_write_enable <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
      checksum           <= '0;
`endif
    end else begin
      case (r_state)
        S_POWER_WAIT: begin
          if (r_wait + 32'd1 >= 32'(STARTUP_WAIT)) r_state <= S_IDLE;
          else                                     r_wait  <= r_wait + 32'd1;
        end
        S_IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            r_sh          <= {READ_CMD, flash_src_addr};
            cache_address <= {cache_dst_addr[ADDR_WIDTH-1:2], 2'b00};
            r_words       <= byte_count[LEN_WIDTH-1:2];
`ifdef FLASH_LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
            r_state       <= S_CMD;
          end
        end
        S_CMD, S_ADDR, S_READ: begin
          // First CMD cycle only drops chip select and presents bit 7; no SPI clocking yet.
          if (r_state == S_CMD && flash_cs) begin
            if (r_words == '0) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              flash_cs   <= 1'b0;
              flash_mosi <= r_sh[31];
              r_div      <= '0;
              r_bits     <= 5'd7;
            end
          end else if (!w_half_done) begin
            r_div <= r_div + DIV_W'(1);
          end else if (!flash_clk) begin
            r_div     <= '0;
            flash_clk <= 1'b1;
            r_rx      <= {r_rx[30:0], flash_miso};
          end else begin
            r_div      <= '0;
            flash_clk  <= 1'b0;
            r_sh       <= {r_sh[30:0], 1'b0};
            flash_mosi <= r_sh[30];
            r_bits     <= r_bits - 5'd1;
            if (r_bits == 5'd0) begin
              if (r_state == S_CMD) begin
                r_state <= S_ADDR;
                r_bits  <= 5'd23;
              end else if (r_state == S_ADDR) begin
                r_state    <= S_READ;
                r_bits     <= 5'd31;
                flash_mosi <= 1'b0;
              end else begin
                r_state            <= S_WR_START;
                cache_data_in      <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                cache_write_enable <= 4'hF;
              end
            end
          end
        end
        S_WR_START: r_state <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (!cache_busy) begin
            cache_write_enable <= 4'h0;
            cache_address      <= cache_address + ADDR_WIDTH'(4);
            r_words            <= r_words - WRD_W'(1);
`ifdef FLASH_LOADER_CHECKSUM_EN
            checksum           <= checksum + cache_data_in;
`endif
            if (r_words == WRD_W'(1)) begin
              flash_cs <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              r_state  <= S_FINISH;
            end else begin
              r_div   <= '0;
              r_bits  <= 5'd31;
              r_state <= S_READ;
            end
          end
        end
        S_FINISH: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_POWER_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Randomised bench for flash_loader: behavioural SPI flash, cache-busy responder and transfer-level reference model.
module tb_flash_loader;
  localparam int HP = 1;
  localparam int SW = 10;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] flash_src_addr = '0;
  logic [31:0] cache_dst_addr = '0;
  logic [23:0] byte_count = '0;
  logic        busy, done, flash_clk, flash_mosi, flash_cs;
  logic        flash_miso = 1'b0;
  logic [31:0] cache_address, cache_data_in;
  logic [3:0]  cache_write_enable;
  logic        cache_busy = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  flash_loader #(.SPI_HALF_PERIOD(HP), .STARTUP_WAIT(SW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .flash_src_addr(flash_src_addr), .cache_dst_addr(cache_dst_addr), .byte_count(byte_count),
    .busy(busy), .done(done), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso), .flash_cs(flash_cs), .cache_address(cache_address),
    .cache_data_in(cache_data_in), .cache_write_enable(cache_write_enable),
`ifdef FLASH_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .cache_busy(cache_busy));

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Flash contents (256-byte image, mirrored across the address space).
  logic [7:0] mem [256];

  int          rise_cnt = 0;
  logic [31:0] cmd_cap = '0;
  int          fd;
  logic [23:0] fa;
  logic [7:0]  fb;

  always @(posedge flash_clk or negedge flash_cs) begin
    if (!flash_clk) rise_cnt = 0;
    else if (!flash_cs) begin
      if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], flash_mosi};
      rise_cnt++;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_cs && rise_cnt >= 32) begin
      fd = rise_cnt - 32;
      fa = cmd_cap[23:0] + 24'(fd / 8);
      fb = mem[fa[7:0]];
      flash_miso = fb[7 - (fd % 8)];
    end
  end

  // Bus monitor and cache-busy responder, sampled on the falling clock edge.
  int          cyc = 0, busy_rise_cyc = 0, done_cyc = 0, cs_fall_cyc = 0;
  int          done_n = 0, cs_fall_n = 0, wr_n = 0, viol = 0, busy_left = 0, nbusy = 0;
  logic        done_bsy = 1'b0;
  logic [31:0] wr_addr [1024];
  logic [31:0] wr_dat  [1024];
  logic [3:0]  wr_we   [1024];
  int          wr_cyc  [1024];
  logic        p_busy = 1'b0, p_cs = 1'b1, p_clk = 1'b0, p_mosi = 1'b0;
  logic [3:0]  p_we = '0;
  logic [31:0] p_addr = '0, p_dat = '0;

  always @(negedge sys_clk) begin
    cyc++;
    if (busy && !p_busy) busy_rise_cyc = cyc;
    if (done) begin done_n++; done_cyc = cyc; done_bsy = busy; end
    if (!flash_cs && p_cs) begin cs_fall_n++; cs_fall_cyc = cyc; end
    if (cache_write_enable != 4'h0 && p_we == 4'h0) begin
      if (wr_n < 1024) begin
        wr_addr[wr_n] = cache_address;
        wr_dat[wr_n]  = cache_data_in;
        wr_we[wr_n]   = cache_write_enable;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
      busy_left = nbusy;
    end else if (cache_write_enable != 4'h0 &&
                 (cache_address != p_addr || cache_data_in != p_dat || cache_write_enable != p_we)) begin
      viol++;
    end
    if (cache_write_enable != 4'h0 && flash_clk) viol++;
    if (flash_clk && p_clk && flash_mosi != p_mosi) viol++;
    cache_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    p_busy = busy; p_cs = flash_cs; p_clk = flash_clk; p_mosi = flash_mosi;
    p_we = cache_write_enable; p_addr = cache_address; p_dat = cache_data_in;
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  int s_wr, s_done, s_csf, s_viol;

  task automatic snap();
    s_wr = wr_n; s_done = done_n; s_csf = cs_fall_n; s_viol = viol;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 100 && !busy; i++) tick();
    chk("busy_rise", busy, 1'b1);
  endtask

  task automatic launch(input logic [23:0] src, input logic [31:0] dst, input logic [23:0] cnt, input int nb);
    tick();
    nbusy = nb;
    flash_src_addr = src; cache_dst_addr = dst; byte_count = cnt;
    snap();
    start = 1'b1;
    wait_busy();
    start = 1'b0;
    flash_src_addr = 24'($urandom); cache_dst_addr = $urandom; byte_count = 24'($urandom);
  endtask

  // Reference: word k holds flash bytes src+4k..src+4k+3 little-endian, written at aligned dst+4k.
  task automatic finish_check(input logic [23:0] src, input logic [31:0] dst, input logic [23:0] cnt, input int nb);
    int          words;
    int          slot;
    logic [23:0] a;
    logic [31:0] exp_w, exp_a, sum;
    words = int'(cnt >> 2);
    sum = '0;
    slot = (nb > 0) ? nb : 1;
    for (int i = 0; i < 5000 && done_n == s_done; i++) tick();
    chk("done_seen", done_n - s_done, 1);
    chk("busy_at_done", done_bsy, 1'b0);
    tick(); tick(); tick();
    chk("done_once", done_n - s_done, 1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cs", flash_cs, 1'b1);
    chk("idle_we", cache_write_enable, 4'h0);
    if (words == 0) begin
      chk("zero_done_lat", done_cyc - busy_rise_cyc, 1);
      chk("zero_no_wr", wr_n - s_wr, 0);
      chk("zero_no_cs", cs_fall_n - s_csf, 0);
    end else begin
      chk("wr_count", wr_n - s_wr, words);
      chk("cs_after_busy", cs_fall_cyc - busy_rise_cyc, 1);
      chk("mosi_cmd_addr", cmd_cap, {8'h03, src});
      chk("hold_viol", viol - s_viol, 0);
      for (int k = 0; k < words && (s_wr + k) < 1024 && k < wr_n - s_wr; k++) begin
        a = src + 24'(4 * k);
        exp_w = {mem[8'(a[7:0] + 8'd3)], mem[8'(a[7:0] + 8'd2)], mem[8'(a[7:0] + 8'd1)], mem[a[7:0]]};
        exp_a = {dst[31:2], 2'b00} + 32'(4 * k);
        sum = sum + exp_w;
        chk("wr_addr", wr_addr[s_wr + k], exp_a);
        chk("wr_data", wr_dat[s_wr + k], exp_w);
        chk("wr_en", {28'd0, wr_we[s_wr + k]}, 32'hF);
        if (k == 0) chk("lat_first", wr_cyc[s_wr] - cs_fall_cyc, 128 * HP);
        else        chk("lat_word", wr_cyc[s_wr + k] - wr_cyc[s_wr + k - 1], 64 * HP + 1 + slot);
      end
      if (wr_n - s_wr == words) chk("lat_done", done_cyc - wr_cyc[s_wr + words - 1], slot + 1);
    end
`ifdef FLASH_LOADER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
  endtask

  logic [23:0] r_src;
  logic [31:0] r_dst;
  logic [23:0] r_cnt;
  int          r_nb;
  int          rel;
  logic [7:0]  dir_bytes [8];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    dir_bytes = '{8'hCD, 8'hAB, 8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 8; i++) mem[i] = dir_bytes[i];

    // Reset state, with start already held high.
    flash_src_addr = 24'h000100; cache_dst_addr = 32'h40; byte_count = 24'd8; start = 1'b1;
    tick(); tick();
    chk("rst_cs", flash_cs, 1'b1);
    chk("rst_clk", flash_clk, 1'b0);
    chk("rst_mosi", flash_mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", cache_write_enable, 4'h0);
    chk("rst_addr", cache_address, 32'h0);
    chk("rst_data", cache_data_in, 32'h0);
    snap();
    sys_rst_n = 1'b1;
    rel = cyc;
    wait_busy();
    chk("startup_wait", busy_rise_cyc - rel, SW + 1);
    start = 1'b0;
    finish_check(24'h000100, 32'h40, 24'd8, 0);
    chk("dir_w0", wr_dat[s_wr], 32'h1234ABCD);
    chk("dir_w1", wr_dat[s_wr + 1], 32'h12345678);
    chk("dir_a1", wr_addr[s_wr + 1], 32'h44);

    // Cache busy stalls, sub-word count, address wrap.
    launch(24'h0000F0, 32'h1003, 24'd12, 5);
    finish_check(24'h0000F0, 32'h1003, 24'd12, 5);
    launch(24'h000010, 32'h200, 24'd3, 0);
    finish_check(24'h000010, 32'h200, 24'd3, 0);
    launch(24'hFFFFFC, 32'hFFFFFFF8, 24'd16, 1);
    finish_check(24'hFFFFFC, 32'hFFFFFFF8, 24'd16, 1);

    for (int t = 0; t < 8; t++) begin
      r_src = 24'($urandom); r_dst = $urandom;
      r_cnt = 24'($urandom_range(0, 23)); r_nb = $urandom_range(0, 5);
      launch(r_src, r_dst, r_cnt, r_nb);
      finish_check(r_src, r_dst, r_cnt, r_nb);
    end

    // Reset in the middle of reading the second word.
    launch(24'h000020, 32'h300, 24'd16, 0);
    for (int i = 0; i < 2000 && !(wr_n - s_wr == 1 && cache_write_enable == 4'h0); i++) tick();
    for (int i = 0; i < 20; i++) tick();
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", flash_cs, 1'b1);
    chk("mid_rst_clk", flash_clk, 1'b0);
    chk("mid_rst_we", cache_write_enable, 4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_one_wr", wr_n - s_wr, 1);
    tick(); tick();
    sys_rst_n = 1'b1;
    launch(24'h000044, 32'h500, 24'd8, 2);
    finish_check(24'h000044, 32'h500, 24'd8, 2);

`ifdef FLASH_LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) mem[8'h80 + i] = 8'hFF;
    mem[8'h84] = 8'h02; mem[8'h85] = 8'h00; mem[8'h86] = 8'h00; mem[8'h87] = 8'h00;
    launch(24'h000080, 32'h0, 24'd8, 0);
    finish_check(24'h000080, 32'h0, 24'd8, 0);
    chk("csum_wrap", checksum, 32'h00000001);
    launch(24'h000080, 32'h0, 24'd0, 0);
    finish_check(24'h000080, 32'h0, 24'd0, 0);
    chk("csum_zero", checksum, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
